csram_arbiter: RTL and testbench

CSRAM_ARBITER -- requirements
Module: csram_arbiter

---
 rtl/csram_pkg.sv | 27 ++
 rtl/csram_rsp_pipe.sv | 45 ++++
 rtl/csram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_csram_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/csram_pkg.sv
// Shared definitions for the CSRAM arbiter: FSM encoding, owner tags, bank decode.
package csram_pkg;

    typedef enum logic [1:0] {
        StArb   = 2'd0,
        StDrain = 2'd1,
        StLock  = 2'd2
    } state_e;

    localparam logic OWN_DBG = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Bank select comes from addr[11:10]
    localparam int unsigned BANK_W   = 2;
    localparam int unsigned BANK_LSB = 10;

    // Only addresses whose top nibble matches this hit the CSRAM
    localparam logic [3:0] CSRAM_REGION = 4'h0;

    function automatic logic [3:0] bank_sel(input logic [31:0] addr);
        logic [3:0] sel;
        sel = '0;
        sel[addr[BANK_LSB +: BANK_W]] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/csram_rsp_pipe.sv
// Two-stage owner/bad-address pipeline that follows each read to its response.
module csram_rsp_pipe
    import csram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic rd_i,
    input  logic owner_i,
    input  logic bad_i,
    output logic s1_vld_o,
    output logic s1_own_o,
    output logic s2_vld_o,
    output logic s2_own_o,
    output logic s2_bad_o
);

    logic s1_vld_q, s1_own_q, s1_bad_q;
    logic s2_vld_q, s2_own_q, s2_bad_q;

    // Shift read tags by one stage per cycle; reset drops anything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s1_own_q <= OWN_DBG;
            s1_bad_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_own_q <= OWN_DBG;
            s2_bad_q <= 1'b0;
        end else begin
            s1_vld_q <= rd_i;
            s1_own_q <= owner_i;
            s1_bad_q <= bad_i;
            s2_vld_q <= s1_vld_q;
            s2_own_q <= s1_own_q;
            s2_bad_q <= s1_bad_q;
        end
    end

    assign s1_vld_o = s1_vld_q;
    assign s1_own_o = s1_own_q;
    assign s2_vld_o = s2_vld_q;
    assign s2_own_o = s2_own_q;
    assign s2_bad_o = s2_bad_q;

endmodule

// File: rtl/csram_arbiter.sv
// Two-requester CSRAM arbiter (debug and DMA) with a debug lock-out FSM.
module csram_arbiter
    import csram_pkg::*;
#(
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned LOCK_TMO = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dbg_en_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dbg_gnt_o,
    output logic        dma_gnt_o,
    output logic        dbg_rvalid_o,
    output logic        dma_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        locked_o,
    output logic [3:0]  csram_cen_o,
    output logic [3:0]  csram_wen_o,
    output logic [31:0] csram_addr_o,
    output logic [31:0] csram_d_o,
    input  logic [31:0] csram_q_i
);

    localparam int unsigned CNT_W = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TMO - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_dma_q;  // 1: most recent grant went to dma
    logic             dbg_gnt, dma_gnt;

    logic             sel_vld, sel_we, sel_own, sel_bad;
    logic [31:0]      sel_addr, sel_wdata;
    logic [3:0]       cen_q, wen_q;
    logic [31:0]      addr_q, d_q;
    logic             err_q;

    logic             s1_vld, s1_own, s2_vld, s2_own, s2_bad;
    logic             dma_rd_busy, dbg_rd_busy;
    logic             unused_addr;

    // Grant decode from the registered state only, so a state change never affects this cycle
    always_comb begin
        dbg_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                StArb: begin
                    if (dbg_req_i && dma_req_i) begin
                        if (RR_EN != 0 && !last_dma_q) dma_gnt = 1'b1;
                        else                           dbg_gnt = 1'b1;
                    end else begin
                        dbg_gnt = dbg_req_i;
                        dma_gnt = dma_req_i;
                    end
                end
                StDrain, StLock: dbg_gnt = dbg_req_i;
                default: ;
            endcase
        end
    end

    // A read is in flight while its tag sits in stage 1; at stage 2 it retires this cycle
    assign dma_rd_busy = s1_vld && (s1_own == OWN_DMA);
    assign dbg_rd_busy = s1_vld && (s1_own == OWN_DBG);

    // Lock FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:   if (dbg_en_i) state_d = StDrain;
            StDrain: begin
                if (!dbg_en_i)                              state_d = StArb;
                else if (!dma_rd_busy || cnt_q == CNT_LAST) state_d = StLock;
            end
            StLock:  if (!dbg_en_i && !dbg_rd_busy) state_d = StArb;
            default: state_d = StArb;
        endcase
    end

    // State, DRAIN cycle counter (saturating, zero on entry) and last-grant pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StArb;
            cnt_q      <= '0;
            last_dma_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q != StDrain)  cnt_q <= '0;
            else if (cnt_q != '1)    cnt_q <= cnt_q + CNT_W'(1);
            if (dbg_gnt)      last_dma_q <= 1'b0;
            else if (dma_gnt) last_dma_q <= 1'b1;
        end
    end

    assign sel_vld   = dbg_gnt || dma_gnt;
    assign sel_we    = dbg_gnt ? dbg_we_i    : dma_we_i;
    assign sel_addr  = dbg_gnt ? dbg_addr_i  : dma_addr_i;
    assign sel_wdata = dbg_gnt ? dbg_wdata_i : dma_wdata_i;
    assign sel_own   = dbg_gnt ? OWN_DBG     : OWN_DMA;
    assign sel_bad   = sel_addr[31:28] != CSRAM_REGION;

    assign unused_addr = ^sel_addr[27:12];

    // Register the granted access onto the CSRAM port; out-of-region accesses only flag err
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cen_q  <= '0;
            wen_q  <= '0;
            addr_q <= '0;
            d_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            cen_q  <= '0;
            wen_q  <= '0;
            addr_q <= '0;
            d_q    <= '0;
            err_q  <= 1'b0;
            if (sel_vld) begin
                if (sel_bad) begin
                    err_q <= 1'b1;
                end else begin
                    cen_q  <= bank_sel(sel_addr);
                    wen_q  <= sel_we ? 4'hF : 4'h0;
                    addr_q <= {20'b0, sel_addr[11:0]};
                    d_q    <= sel_we ? sel_wdata : 32'h0;
                end
            end
        end
    end

    csram_rsp_pipe u_rsp_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_i     (sel_vld && !sel_we),
        .owner_i  (sel_own),
        .bad_i    (sel_bad),
        .s1_vld_o (s1_vld),
        .s1_own_o (s1_own),
        .s2_vld_o (s2_vld),
        .s2_own_o (s2_own),
        .s2_bad_o (s2_bad)
    );

    // Registered outputs are masked while reset is held so every output reads 0
    assign dbg_gnt_o    = dbg_gnt;
    assign dma_gnt_o    = dma_gnt;
    assign locked_o     = !rst_i && (state_q == StLock);
    assign dbg_rvalid_o = !rst_i && s2_vld && (s2_own == OWN_DBG);
    assign dma_rvalid_o = !rst_i && s2_vld && (s2_own == OWN_DMA);
    assign rdata_o      = (!rst_i && s2_vld && !s2_bad) ? csram_q_i : 32'h0;
    assign err_o        = !rst_i && err_q;
    assign csram_cen_o  = rst_i ? 4'h0  : cen_q;
    assign csram_wen_o  = rst_i ? 4'h0  : wen_q;
    assign csram_addr_o = rst_i ? 32'h0 : addr_q;
    assign csram_d_o    = rst_i ? 32'h0 : d_q;

endmodule

// File: tb/tb_csram_arbiter.sv
// Self-checking bench for csram_arbiter: vector table plus scoreboarded CSRAM/response checks.
module tb_csram_arbiter;
    import csram_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dbg_en, dbg_req, dbg_we, dma_req, dma_we;
    logic [31:0] dbg_addr, dbg_wdata, dma_addr, dma_wdata;
    logic        dbg_gnt, dma_gnt, dbg_rvalid, dma_rvalid, err, locked;
    logic [31:0] rdata, csram_addr, csram_d, csram_q;
    logic [3:0]  csram_cen, csram_wen;

    logic [31:0] cyc = 32'd0;
    logic        q_fix = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 32'd1;

    function automatic logic [31:0] q_pat(input logic fix, input logic [31:0] c);
        return fix ? 32'hDEADBEEF : (32'h5A00_0000 ^ (c * 32'h0001_0203));
    endfunction

    assign csram_q = q_pat(q_fix, cyc);

    csram_arbiter #(.RR_EN(1), .LOCK_TMO(TMO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dbg_en_i     (dbg_en),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dma_req_i    (dma_req),
        .dma_we_i     (dma_we),
        .dma_addr_i   (dma_addr),
        .dma_wdata_i  (dma_wdata),
        .dbg_gnt_o    (dbg_gnt),
        .dma_gnt_o    (dma_gnt),
        .dbg_rvalid_o (dbg_rvalid),
        .dma_rvalid_o (dma_rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .locked_o     (locked),
        .csram_cen_o  (csram_cen),
        .csram_wen_o  (csram_wen),
        .csram_addr_o (csram_addr),
        .csram_d_o    (csram_d),
        .csram_q_i    (csram_q)
    );

    typedef struct {
        logic        en, dq, dwe, mq, mwe;
        logic [31:0] da, dwd, ma, mwd;
        logic        e_dbg, e_dma, e_lock;
    } vec_t;

    typedef struct packed {
        logic [31:0] due;
        logic [3:0]  cen;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] d;
        logic        err;
    } acc_t;

    typedef struct packed {
        logic [31:0] due;
        logic        owner;
        logic        bad;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic dq, input logic dwe,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input logic mq, input logic mwe,
                                input logic [31:0] ma, input logic [31:0] mwd,
                                input logic e_dbg, input logic e_dma, input logic e_lock);
        vec_t v;
        v.en = en; v.dq = dq; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.mq = mq; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        v.e_dbg = e_dbg; v.e_dma = e_dma; v.e_lock = e_lock;
        return v;
    endfunction

    // Expected CSRAM-side effect (N+1) and read response (N+2) of a grant in cycle c
    task automatic push_exp(input logic [31:0] c, input logic owner, input logic we,
                            input logic [31:0] a, input logic [31:0] wd);
        acc_t e;
        rsp_t r;
        logic bad;
        bad   = a[31:28] != 4'h0;
        e.due = c + 32'd1;
        e.cen  = bad ? 4'h0 : (4'b0001 << a[11:10]);
        e.wen  = (!bad && we) ? 4'hF : 4'h0;
        e.addr = bad ? 32'h0 : {20'h0, a[11:0]};
        e.d    = (!bad && we) ? wd : 32'h0;
        e.err  = bad;
        acc_q.push_back(e);
        if (!we) begin
            r.due = c + 32'd2; r.owner = owner; r.bad = bad;
            rsp_q.push_back(r);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk_i); #1;
        dbg_en = v.en; dbg_req = v.dq; dbg_we = v.dwe; dbg_addr = v.da; dbg_wdata = v.dwd;
        dma_req = v.mq; dma_we = v.mwe; dma_addr = v.ma; dma_wdata = v.mwd;
        @(negedge clk_i);
        chk("gnt_lock", 128'({dbg_gnt, dma_gnt, locked}), 128'({v.e_dbg, v.e_dma, v.e_lock}));
        if (v.e_dbg) push_exp(cyc, OWN_DBG, v.dwe, v.da, v.dwd);
        if (v.e_dma) push_exp(cyc, OWN_DMA, v.mwe, v.ma, v.mwd);
    endtask

    // Every cycle: CSRAM port and response outputs against the scoreboard (idle => all zero)
    always @(negedge clk_i) begin : mon
        acc_t        ea;
        rsp_t        er;
        logic [33:0] ersp;
        ea = '0;
        if (acc_q.size() != 0 && acc_q[0].due == cyc) ea = acc_q.pop_front();
        chk("csram_port", 128'({csram_cen, csram_wen, csram_addr, csram_d, err}),
            128'({ea.cen, ea.wen, ea.addr, ea.d, ea.err}));
        ersp = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            er   = rsp_q.pop_front();
            ersp = {er.owner == OWN_DBG, er.owner == OWN_DMA,
                    er.bad ? 32'h0 : q_pat(q_fix, cyc)};
        end
        chk("response", 128'({dbg_rvalid, dma_rvalid, rdata}), 128'(ersp));
    end

    initial begin
        rst_i = 1'b1; dbg_en = 1'b0; dbg_we = 1'b0; dma_we = 1'b0;
        dbg_req = 1'b1; dma_req = 1'b1;
        dbg_addr = 32'h0; dbg_wdata = 32'h0; dma_addr = 32'h0; dma_wdata = 32'h0;

        // Reset with both requests high: no grants, not locked
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("reset_gnt", 128'({dbg_gnt, dma_gnt, locked}), 128'(3'b000));
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; dbg_req = 1'b0; dma_req = 1'b0;
        @(negedge clk_i);

        //         en dq dwe da             dwd           mq mwe ma             mwd       gD gM L
        tbl.push_back(mk(0,1,0,32'h0000_0405,32'h0,       0,0,32'h0,         32'h0,     1,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       0,0,32'h0,         32'h0,     0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       0,0,32'h0,         32'h0,     0,0,0));
        tbl.push_back(mk(0,1,0,32'h0000_0000,32'h0,       1,0,32'h0000_0800, 32'h0,     0,1,0));
        tbl.push_back(mk(0,1,0,32'h0000_0400,32'h0,       1,0,32'h0000_0C04, 32'h0,     1,0,0));
        tbl.push_back(mk(0,1,0,32'h0000_0404,32'h0,       1,0,32'h0000_0008, 32'h0,     0,1,0));
        tbl.push_back(mk(0,1,0,32'h0000_0FFC,32'h0,       1,0,32'h0000_080C, 32'h0,     1,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,1,32'h1000_0000, 32'h1234,  0,1,0));
        tbl.push_back(mk(0,1,1,32'h0000_0ABC,32'hCAFEF00D,0,0,32'h0,         32'h0,     1,0,0));
        tbl.push_back(mk(0,1,0,32'h2000_0010,32'h0,       0,0,32'h0,         32'h0,     1,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,1,0));
        tbl.push_back(mk(1,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,1,0));
        tbl.push_back(mk(1,1,0,32'h0000_0004,32'h0,       1,0,32'h0000_0C00, 32'h0,     1,0,0));
        tbl.push_back(mk(1,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,0,1));
        tbl.push_back(mk(1,1,0,32'h0000_0808,32'h0,       1,0,32'h0000_0C00, 32'h0,     1,0,1));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,0,1));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,0,1));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,0,32'h0000_0C00, 32'h0,     0,1,0));
        tbl.push_back(mk(1,0,0,32'h0,        32'h0,       0,0,32'h0,         32'h0,     0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,0,32'h0000_0400, 32'h0,     0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       1,0,32'h0000_0400, 32'h0,     0,1,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       0,0,32'h0,         32'h0,     0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h0,       0,0,32'h0,         32'h0,     0,0,0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        @(posedge clk_i); #1;
        q_fix = 1'b0;
        @(negedge clk_i);

        // Both requesters reading every cycle: strict alternation starting with dbg
        for (int i = 0; i < 8; i++) begin
            step(mk(0,1,0,32'h0000_0100 + 32'(i*4),32'h0, 1,0,32'h0000_0900 + 32'(i*4),32'h0,
                    (i % 2) == 0, (i % 2) == 1, 0));
        end
        step(mk(0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));
        step(mk(0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));

        // Reset one cycle after a dbg read grant: response discarded, pointer back to dma
        step(mk(0,1,0,32'h0000_040C,32'h0, 0,0,32'h0,32'h0, 1,0,0));
        @(posedge clk_i); #1;
        rst_i = 1'b1; dbg_req = 1'b1; dma_req = 1'b1; dbg_we = 1'b0; dma_we = 1'b0;
        acc_q.delete();
        rsp_q.delete();
        @(negedge clk_i);
        chk("midrst_gnt", 128'({dbg_gnt, dma_gnt, locked}), 128'(3'b000));
        @(posedge clk_i); #1;
        rst_i = 1'b0; dbg_req = 1'b0; dma_req = 1'b0;
        @(negedge clk_i);
        step(mk(0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));
        step(mk(0,1,0,32'h0000_0010,32'h0, 1,0,32'h0000_0020,32'h0, 1,0,0));
        step(mk(0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));
        step(mk(0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));

        // DRAIN timeout with the dma in-flight indication held busy
        force dut.dma_rd_busy = 1'b1;
        step(mk(1,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));
        for (int k = 0; k < TMO; k++) begin
            step(mk(1,0,0,32'h0,32'h0, 1,0,32'h0000_0400,32'h0, 0,0,0));
        end
        step(mk(1,0,0,32'h0,32'h0, 1,0,32'h0000_0400,32'h0, 0,0,1));
        release dut.dma_rd_busy;
        step(mk(0,0,0,32'h0,32'h0, 1,0,32'h0000_0400,32'h0, 0,0,1));
        step(mk(0,0,0,32'h0,32'h0, 1,0,32'h0000_0400,32'h0, 0,1,0));
        for (int i = 0; i < 3; i++) step(mk(0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0));

        chk("sb_drained", 128'(acc_q.size() + rsp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
